// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder: word alignment search on control tokens, then 8b/10b-style
// TMDS video/control decode through a two-stage pipeline.
module tmds_rx_decoder #(
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOCK_TOKENS    = 8,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] raw_word,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] align_offset,
    output logic       token_seen
);

    localparam int unsigned HW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int unsigned VW = $clog2(LOCK_TOKENS + 1);
    localparam int unsigned LW = $clog2(LOSS_TIMEOUT + 1);

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

    state_e          state_q, state_d;
    logic [3:0]      offset_q, offset_d, offset_next;
    logic [HW-1:0]   hunt_cnt_q, hunt_cnt_d;
    logic [VW-1:0]   vfy_cnt_q, vfy_cnt_d;
    logic [LW-1:0]   loss_cnt_q, loss_cnt_d;

    logic [9:0]      raw_prev_q;
    logic [19:0]     window;
    logic [9:0]      aligned;
    logic [9:0]      s1_q;

    logic            tok;
    logic [1:0]      tok_ctrl;
    logic [7:0]      qp;
    logic [7:0]      vid;

    logic [7:0]      data_q;
    logic [1:0]      ctrl_q, ctrl_last_q;
    logic            de_q, locked_q, token_seen_q;

    // Bit 0 is earliest on the wire, so the previous word sits in the low half.
    assign window  = {raw_word, raw_prev_q};
    assign aligned = window[offset_q +: 10];

    always_comb begin
        tok      = 1'b1;
        tok_ctrl = 2'b00;
        case (s1_q)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        tok      = 1'b0;
        endcase
    end

    always_comb begin
        qp     = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
        vid    = '0;
        vid[0] = qp[0];
        for (int i = 1; i < 8; i++) begin
            vid[i] = s1_q[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
        end
    end

    assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        hunt_cnt_d = hunt_cnt_q;
        vfy_cnt_d  = vfy_cnt_q;
        loss_cnt_d = loss_cnt_q;
        unique case (state_q)
            StHunt: begin
                // A token wins over a coincident search timeout.
                if (tok) begin
                    hunt_cnt_d = '0;
                    if (LOCK_TOKENS <= 1) begin
                        state_d    = StLocked;
                        loss_cnt_d = '0;
                    end else begin
                        state_d   = StVerify;
                        vfy_cnt_d = VW'(1);
                    end
                end else if (hunt_cnt_q == HW'(SEARCH_TIMEOUT - 1)) begin
                    offset_d   = offset_next;
                    hunt_cnt_d = '0;
                end else begin
                    hunt_cnt_d = hunt_cnt_q + 1'b1;
                end
            end
            StVerify: begin
                if (tok) begin
                    if (vfy_cnt_q == VW'(LOCK_TOKENS - 1)) begin
                        state_d    = StLocked;
                        vfy_cnt_d  = '0;
                        loss_cnt_d = '0;
                    end else begin
                        vfy_cnt_d = vfy_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = StHunt;
                    offset_d   = offset_next;
                    vfy_cnt_d  = '0;
                    hunt_cnt_d = '0;
                end
            end
            StLocked: begin
                if (tok) begin
                    loss_cnt_d = '0;
                end else if (loss_cnt_q == LW'(LOSS_TIMEOUT - 1)) begin
                    state_d    = StHunt;
                    loss_cnt_d = '0;
                    hunt_cnt_d = '0;
                end else begin
                    loss_cnt_d = loss_cnt_q + 1'b1;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q    <= StHunt;
            offset_q   <= '0;
            hunt_cnt_q <= '0;
            vfy_cnt_q  <= '0;
            loss_cnt_q <= '0;
            raw_prev_q <= '0;
            s1_q       <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            hunt_cnt_q <= hunt_cnt_d;
            vfy_cnt_q  <= vfy_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            raw_prev_q <= raw_word;
            s1_q       <= aligned;
        end
    end

    // Stage 2: outputs are gated by the state the word was judged in, so locked and de agree.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            data_q       <= '0;
            ctrl_q       <= '0;
            ctrl_last_q  <= '0;
            de_q         <= 1'b0;
            locked_q     <= 1'b0;
            token_seen_q <= 1'b0;
        end else begin
            token_seen_q <= tok;
            locked_q     <= (state_q == StLocked);
            if (tok) begin
                ctrl_last_q <= tok_ctrl;
            end
            if (state_q == StLocked) begin
                de_q   <= ~tok;
                data_q <= tok ? 8'h00 : vid;
                ctrl_q <= tok ? tok_ctrl : ctrl_last_q;
            end else begin
                de_q   <= 1'b0;
                data_q <= '0;
                ctrl_q <= '0;
            end
        end
    end

    assign data         = data_q;
    assign ctrl         = ctrl_q;
    assign de           = de_q;
    assign locked       = locked_q;
    assign align_offset = offset_q;
    assign token_seen   = token_seen_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Scoreboard bench for tmds_rx_decoder: directed token/video streams at offsets 0 and 3,
// search timeouts, VERIFY failure, lock loss and mid-lock reset.
module tb_tmds_rx_decoder;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] V0  = 10'b0100000000;  // -> 0x00
    localparam logic [9:0] V1  = 10'b0100001111;  // -> 0x11
    localparam logic [9:0] V2  = 10'b1000110011;  // -> 0xAA

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_word = '0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] align_offset;
    logic       token_seen;

    tmds_rx_decoder dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .raw_word     (raw_word),
        .data         (data),
        .ctrl         (ctrl),
        .de           (de),
        .locked       (locked),
        .align_offset (align_offset),
        .token_seen   (token_seen)
    );

    always #5 pixel_clk = ~pixel_clk;

    int unsigned cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    typedef struct {
        logic        tok;
        logic        de;
        logic [7:0]  data;
        logic [1:0]  ctrl;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int unsigned sb_from = 32'hFFFF_FFFF;
    int unsigned sb_to   = 32'hFFFF_FFFF;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        shifted = 1'b0;
    logic [9:0]  prev_w = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // kind: 0 no output event, 1 token event, 2 video event
    task automatic send(input logic [9:0] w, input int kind, input logic [7:0] edata,
                        input logic [1:0] ectrl);
        exp_t e;
        // Shifted mode places each logical word at bit offset 3 of the raw stream.
        raw_word = shifted ? {w[6:0], prev_w[9:7]} : w;
        prev_w   = w;
        if (kind != 0) begin
            e.tok  = (kind == 1);
            e.de   = (kind == 2);
            e.data = (kind == 2) ? edata : 8'h00;
            e.ctrl = ectrl;
            e.due  = cyc + 3;
            sbq.push_back(e);
        end
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic tok(input logic [9:0] w, input logic [1:0] c);
        send(w, 1, 8'h00, c);
    endtask

    task automatic vid(input logic [9:0] w, input logic [7:0] d, input logic [1:0] c);
        send(w, 2, d, c);
    endtask

    task automatic raw(input logic [9:0] w);
        send(w, 0, 8'h00, 2'b00);
    endtask

    task automatic open_sb();
        chk("sb_leftover", sbq.size(), 0);
        sbq.delete();
        sb_from = cyc;
        sb_to   = 32'hFFFF_FFFF;
    endtask

    task automatic flush(input logic [9:0] w);
        sb_to = (sbq.size() != 0) ? sbq[$].due : cyc;
        repeat (3) raw(w);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        raw_word = '0;
        prev_w   = '0;
        repeat (2) @(posedge pixel_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_ctrl"}, ctrl, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_token_seen"}, token_seen, 0);
        chk({tag, "_offset"}, align_offset, 0);
    endtask

    always @(negedge pixel_clk) begin
        if (!rst && cyc >= sb_from && cyc <= sb_to) begin
            if (token_seen || de) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got tok=%b de=%b data=%h ctrl=%b at %0d, required none",
                             token_seen, de, data, ctrl, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    if (token_seen !== mon_e.tok || de !== mon_e.de || data !== mon_e.data ||
                        ctrl !== mon_e.ctrl || cyc != mon_e.due) begin
                        n_bad++;
                        $display("FAIL event: got tok=%b de=%b data=%h ctrl=%b at %0d, required tok=%b de=%b data=%h ctrl=%b at %0d",
                                 token_seen, de, data, ctrl, cyc,
                                 mon_e.tok, mon_e.de, mon_e.data, mon_e.ctrl, mon_e.due);
                    end
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                mon_e = sbq.pop_front();
                $display("FAIL missing_event: got nothing at %0d, required tok=%b de=%b data=%h ctrl=%b",
                         cyc, mon_e.tok, mon_e.de, mon_e.data, mon_e.ctrl);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned step_cyc [1:3];
        int unsigned lock_cyc;

        // Reset values
        do_reset();
        chk_zero("reset");
        open_sb();

        // Aligned lock at offset 0, then video and control decode
        repeat (8) tok(T00, 2'b00);
        vid(V0, 8'h00, 2'b00);
        tok(T11, 2'b11);
        vid(V1, 8'h11, 2'b11);
        vid(V2, 8'hAA, 2'b11);
        chk("b_locked", locked, 1);
        chk("b_offset", align_offset, 0);

        // One-cycle reset while locked with T11 in flight
        flush(V0);
        raw(T11);
        rst = 1'b1;
        @(posedge pixel_clk);
        #1;
        rst = 1'b0;
        chk_zero("midrst");
        open_sb();
        repeat (8) tok(T00, 2'b00);
        vid(V0, 8'h00, 2'b00);
        vid(V0, 8'h00, 2'b00);
        chk("g_not_yet_locked", locked, 0);
        vid(V0, 8'h00, 2'b00);
        chk("g_relocked", locked, 1);

        // Spurious token then non-token in VERIFY
        flush(V0);
        do_reset();
        open_sb();
        repeat (5) raw(10'h000);
        tok(T00, 2'b00);
        repeat (5) raw(10'h000);
        chk("c_offset", align_offset, 1);
        chk("c_locked", locked, 0);

        // Token coincides with the last search-timeout cycle
        do_reset();
        open_sb();
        for (int i = 0; i < 2045; i++) raw(10'h000);
        repeat (8) tok(T00, 2'b00);
        repeat (3) vid(V0, 8'h00, 2'b00);
        chk("d_offset", align_offset, 0);
        chk("d_locked", locked, 1);

        // Stream shifted by 3 bits: search steps to offset 3 and locks
        flush(V0);
        do_reset();
        shifted  = 1'b1;
        c0       = cyc;
        step_cyc = '{0, 0, 0};
        lock_cyc = 0;
        for (int i = 0; i < 7000 && lock_cyc == 0; i++) begin
            raw(T00);
            for (int k = 1; k <= 3; k++) begin
                if (step_cyc[k] == 0 && align_offset == 4'(k)) step_cyc[k] = cyc - c0;
            end
            if (locked) lock_cyc = cyc - c0;
        end
        chk("e_step1_cycle", step_cyc[1], 2048);
        chk("e_step2_cycle", step_cyc[2], 4096);
        chk("e_step3_cycle", step_cyc[3], 6144);
        chk("e_lock_cycle", lock_cyc, 6154);
        chk("e_offset", align_offset, 3);
        repeat (3) raw(T00);
        chk("sb_leftover", sbq.size(), 0);
        sbq.delete();
        sb_from = cyc + 3;
        sb_to   = 32'hFFFF_FFFF;
        vid(V1, 8'h11, 2'b00);
        tok(T01, 2'b01);
        vid(V2, 8'hAA, 2'b01);

        // 4096 token-free words while locked: lock drops, offset retained
        repeat (4095) vid(V1, 8'h11, 2'b01);
        repeat (6) raw(V1);
        chk("f_unlocked", locked, 0);
        chk("f_offset", align_offset, 3);
        repeat (8) tok(T00, 2'b00);
        repeat (3) vid(V1, 8'h11, 2'b00);
        chk("f_relocked", locked, 1);
        chk("f_offset2", align_offset, 3);

        flush(V1);
        chk("sb_final_leftover", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
